weight_quantizer: RTL

- Streaming symmetric int8 quantizer that produces the quantized weight stream consumed by the vector-multiply datapath.
- Accepts N Q16.16 signed weights and finds the maximum magnitude.
- Selects a power-of-two scale so the largest weight fits in ±127.
- Emits N int8 weights plus the scale shift, so the multiplier side can dequantize as w ≈ q · 2^shift / 2^16.

---
 rtl/weight_quantizer_if.sv | 25 ++
 rtl/weight_quantizer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/weight_quantizer_if.sv
// Handshake/stream bundle for the weight quantizer.
// The master side drives start, the weight stream and downstream ready.
// The slave side (the quantizer) returns the int8 stream, the scale shift and status.
interface weight_quantizer_if;
   logic               start_i;
   logic               w_valid_i;
   logic signed [31:0] w_i;
   logic               q_ready_i;
   logic               q_valid_o;
   logic signed [7:0]  q_o;
   logic               q_last_o;
   logic [4:0]         shift_o;
   logic               busy_o;
   logic               done_o;

   modport master (
      output start_i, w_valid_i, w_i, q_ready_i,
      input  q_valid_o, q_o, q_last_o, shift_o, busy_o, done_o
   );

   modport slave (
      input  start_i, w_valid_i, w_i, q_ready_i,
      output q_valid_o, q_o, q_last_o, shift_o, busy_o, done_o
   );
endinterface

// File: rtl/weight_quantizer.sv
// Streaming symmetric int8 quantizer.
// Buffers N Q16.16 weights and tracks their largest magnitude. It then picks a
// power-of-two shift k so the largest weight lands within +/-127, and streams
// out round-half-up, saturated int8 values with a valid/ready handshake.
module weight_quantizer #(
   parameter int N  = 8,
   parameter int CW = 3
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   weight_quantizer_if.slave bus
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_EMIT, S_DONE} state_t;

   state_t             r_state;
   logic [CW-1:0]      r_wcnt;
   logic [CW-1:0]      r_rcnt;
   logic [31:0]        r_maxabs;
   logic signed [31:0] r_buf [N];
   logic [4:0]         r_shift;
   logic signed [7:0]  r_q;
   logic               r_qvld;
   logic               r_qlast;
   logic               r_busy;
   logic               r_done;

   logic               w_wacc;
   logic [31:0]        w_abs;
   logic               w_hs;
   logic [CW-1:0]      w_ridx;
   logic               w_load;
   logic signed [7:0]  w_qnext;

   // Magnitude as a 32-bit unsigned value; -2^31 maps to 2^31.
   function automatic logic [31:0] abs32(input logic signed [31:0] v);
      logic [31:0] u;
      u = v;
      return u[31] ? (~u + 32'd1) : u;
   endfunction

   // Shift that brings the MSB of the largest magnitude down to bit 6.
   function automatic logic [4:0] shift_for(input logic [31:0] m);
      logic [4:0] p;
      p = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (m[i]) p = 5'(i);
      end
      return (p > 5'd6) ? (p - 5'd6) : 5'd0;
   endfunction

   // Round half toward +inf, arithmetic shift, clamp to the symmetric int8 range.
   // The 33-bit sum keeps w + 2^(k-1) from wrapping.
   function automatic logic signed [7:0] quant(input logic signed [31:0] w,
                                               input logic [4:0]         k);
      logic signed [32:0] rnd;
      logic signed [32:0] sum;
      logic signed [32:0] sh;
      rnd = (k == 5'd0) ? 33'sd0 : (33'sd1 <<< (k - 5'd1));
      sum = {w[31], w} + rnd;
      sh  = sum >>> k;
      if (sh > 33'sd127)       return 8'sd127;
      else if (sh < -33'sd127) return -8'sd127;
      else                     return sh[7:0];
   endfunction

   assign w_wacc  = (r_state == S_LOAD) && bus.w_valid_i;
   assign w_abs   = abs32(bus.w_i);
   assign w_hs    = r_qvld && bus.q_ready_i;
   // Next buffer slot to present: the current one if nothing is shown yet,
   // otherwise the one after the slot being handed off.
   assign w_ridx  = r_qvld ? (r_rcnt + 1'b1) : r_rcnt;
   assign w_load  = (r_state == S_EMIT) && (!r_qvld || (w_hs && !r_qlast));
   assign w_qnext = quant(r_buf[w_ridx], r_shift);

   // Sample storage; contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk_i) begin
      if (w_wacc) r_buf[r_wcnt] <= bus.w_i;
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state  <= S_IDLE;
         r_wcnt   <= '0;
         r_rcnt   <= '0;
         r_maxabs <= '0;
         r_shift  <= '0;
         r_q      <= '0;
         r_qvld   <= 1'b0;
         r_qlast  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start_i) begin
                  r_state  <= S_LOAD;
                  r_wcnt   <= '0;
                  r_rcnt   <= '0;
                  r_maxabs <= '0;
                  r_busy   <= 1'b1;
               end
            end
            S_LOAD: begin
               if (bus.w_valid_i) begin
                  r_wcnt <= r_wcnt + 1'b1;
                  if (w_abs > r_maxabs) r_maxabs <= w_abs;
                  if (r_wcnt == CW'(N - 1)) r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_shift <= shift_for(r_maxabs);
               r_state <= S_EMIT;
            end
            S_EMIT: begin
               if (w_hs) begin
                  if (r_qlast) begin
                     r_qvld  <= 1'b0;
                     r_qlast <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_rcnt <= r_rcnt + 1'b1;
                  end
               end
               if (w_load) begin
                  r_q     <= w_qnext;
                  r_qvld  <= 1'b1;
                  r_qlast <= (w_ridx == CW'(N - 1));
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.q_valid_o = r_qvld;
   assign bus.q_o       = r_q;
   assign bus.q_last_o  = r_qlast;
   assign bus.shift_o   = r_shift;
   assign bus.busy_o    = r_busy;
   assign bus.done_o    = r_done;

endmodule
